// File: rtl/fd_pipe_reg_if.sv
// rtl/fd_pipe_reg_if.sv - Fetch/Decode pipeline register signal bundle
//
// Purpose: groups the control, fetch-side and decode-side signals of the
// F/D pipeline register so the stage boundary is one port.
//
// Signals:
//   en         pipeline advance enable (0 = stall)
//   Req        exception/interrupt flush request from CP0
//   F_pc       fetch-stage PC
//   F_instr    instruction word read at F_pc
//   F_AdEL     fetch address error
//   F_BD       fetch instruction sits in a delay slot
//   D_pc       registered D-stage PC
//   D_instr    registered D-stage instruction (0 when bubbled or faulted)
//   D_ExcCode  registered exception code (0 = none)
//   D_BD       registered delay-slot flag
//   D_valid    1 = real instruction, 0 = bubble/flushed slot
//
// Modports:
//   master  fetch/control side: drives en, Req and F_*, observes D_*
//   slave   the pipeline register: consumes en, Req and F_*, drives D_*

interface fd_pipe_reg_if;
    logic        en;
    logic        Req;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic        F_AdEL;
    logic        F_BD;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic [4:0]  D_ExcCode;
    logic        D_BD;
    logic        D_valid;

    modport master (
        output en,
        output Req,
        output F_pc,
        output F_instr,
        output F_AdEL,
        output F_BD,
        input  D_pc,
        input  D_instr,
        input  D_ExcCode,
        input  D_BD,
        input  D_valid
    );

    modport slave (
        input  en,
        input  Req,
        input  F_pc,
        input  F_instr,
        input  F_AdEL,
        input  F_BD,
        output D_pc,
        output D_instr,
        output D_ExcCode,
        output D_BD,
        output D_valid
    );
endinterface

// File: rtl/fd_pipe_reg.sv
// rtl/fd_pipe_reg.sv - Fetch/Decode pipeline register of the five-stage MIPS core
//
// Purpose: captures the fetch-stage PC, instruction, address-error flag and
// delay-slot flag on each enabled edge and presents them to decode as
// registered values, encoding a fetch address error as an ExcCode.
// Supports stall (hold), flush to the handler address and bubble marking.
//
// Ports:
//   clk    system clock, all state updates on posedge
//   reset  synchronous active-high reset, highest priority
//   fd     fd_pipe_reg_if.slave bundle (en, Req, F_* in; D_* out)
//
// Parameters:
//   RESET_PC    D_pc after reset
//   HANDLER_PC  D_pc after an exception/interrupt flush
//   EXC_ADEL    ExcCode emitted for a fetch address error

module fd_pipe_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic          clk,
    input  logic          reset,
    fd_pipe_reg_if.slave  fd
);

    logic [31:0] d_pc_q,       d_pc_d;
    logic [31:0] d_instr_q,    d_instr_d;
    logic [4:0]  d_exc_code_q, d_exc_code_d;
    logic        d_bd_q,       d_bd_d;
    logic        d_valid_q,    d_valid_d;

    // Priority below reset: Req > !en > load. Reset is applied in the
    // register process so it overrides everything computed here.
    always_comb begin
        d_pc_d       = d_pc_q;
        d_instr_d    = d_instr_q;
        d_exc_code_d = d_exc_code_q;
        d_bd_d       = d_bd_q;
        d_valid_d    = d_valid_q;

        if (fd.Req) begin
            // Flushed slot carries the handler PC so the PC seen by CP0
            // moves monotonically into the handler; it is never executed.
            d_pc_d       = HANDLER_PC;
            d_instr_d    = 32'h0;
            d_exc_code_d = 5'd0;
            d_bd_d       = 1'b0;
            d_valid_d    = 1'b0;
        end else if (fd.en) begin
            d_pc_d    = fd.F_pc;
            d_bd_d    = fd.F_BD;
            d_valid_d = 1'b1;
            if (fd.F_AdEL) begin
                // Faulting fetch: keep the bad address for EPC/BadVAddr but
                // force a nop so the (possibly garbage/X) word is never decoded.
                d_instr_d    = 32'h0;
                d_exc_code_d = EXC_ADEL;
            end else begin
                d_instr_d    = fd.F_instr;
                d_exc_code_d = 5'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_pc_q       <= RESET_PC;
            d_instr_q    <= 32'h0;
            d_exc_code_q <= 5'd0;
            d_bd_q       <= 1'b0;
            d_valid_q    <= 1'b0;
        end else begin
            d_pc_q       <= d_pc_d;
            d_instr_q    <= d_instr_d;
            d_exc_code_q <= d_exc_code_d;
            d_bd_q       <= d_bd_d;
            d_valid_q    <= d_valid_d;
        end
    end

    // Outputs come straight from the flops: no input-to-output path.
    assign fd.D_pc      = d_pc_q;
    assign fd.D_instr   = d_instr_q;
    assign fd.D_ExcCode = d_exc_code_q;
    assign fd.D_BD      = d_bd_q;
    assign fd.D_valid   = d_valid_q;

endmodule

// File: tb/tb_fd_pipe_reg.sv
// tb/tb_fd_pipe_reg.sv - directed self-checking bench for fd_pipe_reg

module tb_fd_pipe_reg;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fd_pipe_reg_if fd ();

    fd_pipe_reg dut (
        .clk   (clk),
        .reset (reset),
        .fd    (fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_d(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [4:0] exc, input logic bd, input logic valid);
        check({tag, ".pc"},    fd.D_pc, pc);
        check({tag, ".instr"}, fd.D_instr, instr);
        check({tag, ".exc"},   {27'd0, fd.D_ExcCode}, {27'd0, exc});
        check({tag, ".bd"},    {31'd0, fd.D_BD}, {31'd0, bd});
        check({tag, ".valid"}, {31'd0, fd.D_valid}, {31'd0, valid});
    endtask

    // Advance one rising edge, then settle past it before checking/driving.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic req, input logic en,
                         input logic [31:0] pc, input logic [31:0] instr,
                         input logic adel, input logic bd);
        reset      = r;
        fd.Req     = req;
        fd.en      = en;
        fd.F_pc    = pc;
        fd.F_instr = instr;
        fd.F_AdEL  = adel;
        fd.F_BD    = bd;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // Reset with arbitrary inputs.
        drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
        tick;
        check_d("reset", 32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0);

        // Normal load, one-cycle latency.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_3004, 32'h2408_0005, 1'b0, 1'b1);
        tick;
        check_d("load", 32'h0000_3004, 32'h2408_0005, 5'd0, 1'b1, 1'b1);

        // Outputs must not follow inputs between edges.
        drive(1'b0, 1'b1, 1'b1, 32'h0000_5555, 32'hAAAA_AAAA, 1'b1, 1'b0);
        #2;
        check_d("no_comb", 32'h0000_3004, 32'h2408_0005, 5'd0, 1'b1, 1'b1);

        // Fetch address error: forced nop, ExcCode=4, faulting PC kept.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_3002, 32'hFFFF_FFFF, 1'b1, 1'b0);
        tick;
        check_d("adel", 32'h0000_3002, 32'h0, 5'd4, 1'b0, 1'b1);

        // X on F_instr while faulted must not reach D_instr.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_3006, 32'hxxxx_xxxx, 1'b1, 1'b1);
        tick;
        check_d("adel_x", 32'h0000_3006, 32'h0, 5'd4, 1'b1, 1'b1);

        // Stall hold: load 0x3008 then three stalled edges with changing inputs.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_3008, 32'h0000_0000, 1'b0, 1'b0);
        tick;
        check_d("pre_stall", 32'h0000_3008, 32'h0, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0000_3100 + 32'(i * 4), $urandom, i[0], 1'b1);
            tick;
            check_d("stall", 32'h0000_3008, 32'h0, 5'd0, 1'b0, 1'b1);
        end
        drive(1'b0, 1'b0, 1'b1, 32'h0000_300C, 32'h8C09_0000, 1'b0, 1'b0);
        tick;
        check_d("unstall", 32'h0000_300C, 32'h8C09_0000, 5'd0, 1'b0, 1'b1);

        // Req during stall flushes to handler.
        drive(1'b0, 1'b1, 1'b0, 32'h0000_3010, 32'h1111_1111, 1'b0, 1'b1);
        tick;
        check_d("req_stall", 32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0);

        // Stalled bubble holds D_valid=0.
        drive(1'b0, 1'b0, 1'b0, 32'h0000_3014, 32'h2222_2222, 1'b0, 1'b1);
        tick;
        check_d("bubble_hold", 32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0);

        // Load with a delay-slot fault, then Req with en=1 still flushes.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_3018, 32'h3333_3333, 1'b1, 1'b1);
        tick;
        check_d("adel_bd", 32'h0000_3018, 32'h0, 5'd4, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_301C, 32'h4444_4444, 1'b0, 1'b1);
        tick;
        check_d("req_en", 32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0);

        // Back-to-back loads overwrite every field.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_4184, 32'h0000_000C, 1'b0, 1'b1);
        tick;
        check_d("b2b_0", 32'h0000_4184, 32'h0000_000C, 5'd0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_4188, 32'h4200_0018, 1'b0, 1'b0);
        tick;
        check_d("b2b_1", 32'h0000_4188, 32'h4200_0018, 5'd0, 1'b0, 1'b1);

        // Reset and Req on the same edge: reset wins.
        drive(1'b1, 1'b1, 1'b1, 32'h0000_3010, 32'h5555_5555, 1'b0, 1'b1);
        tick;
        check_d("reset_req", 32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0);

        // Single reset edge fully recovers; next load is normal.
        drive(1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h3C1D_0000, 1'b0, 1'b0);
        tick;
        check_d("post_reset", 32'h0000_3000, 32'h3C1D_0000, 5'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fd_pipe_reg.md
# fd_pipe_reg

Fetch/Decode pipeline register of the five-stage MIPS core, directly downstream of the fetch unit. Each enabled cycle it captures the fetch-stage PC, instruction word, fetch address-error flag and delay-slot flag. It presents them to decode as registered D-stage values and encodes fetch exceptions into a 5-bit ExcCode. It supports stall (hold), interrupt/exception flush to the handler address, and bubble marking via a valid bit.

## Interface
- Parameters
- RESET_PC, 32'h0000_3000, D_pc value after reset
- HANDLER_PC, 32'h0000_4180, D_pc value after an exception/interrupt flush
- EXC_ADEL, 5'd4, ExcCode emitted for a fetch address error
- Ports
- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high; highest priority
- en  input  1  pipeline advance enable (0 = stall, hold contents)
- Req  input  1  exception/interrupt request from CP0; flushes register
- F_pc  input  32  fetch-stage PC (already EPC-substituted by fetch on eret)
- F_instr  input  32  instruction word read at F_pc
- F_AdEL  input  1  fetch address error (misaligned or outside 0x3000–0x6ffc)
- F_BD  input  1  instruction in F is a branch/jump delay slot
- D_pc  output  32  registered PC of D-stage instruction
- D_instr  output  32  registered instruction (0 = nop when bubbled or faulted)
- D_ExcCode  output  5  registered exception code (0 = none)
- D_BD  output  1  registered delay-slot flag
- D_valid  output  1  1 = real instruction in D; 0 = bubble/flushed slot

## Operation
- One register bank: {D_pc, D_instr, D_ExcCode, D_BD, D_valid}. Outputs drive directly from the flops, with no combinational path from inputs to outputs.
- Per-cycle priority at posedge: reset > Req > !en > load.
- reset=1: D_pc=RESET_PC, D_instr=0, D_ExcCode=0, D_BD=0, D_valid=0.
- Req=1 (reset=0): flush, regardless of en. D_pc=HANDLER_PC, D_instr=0, D_ExcCode=0, D_BD=0, D_valid=0.
- en=0 (reset=0, Req=0): all fields hold their previous value, including D_valid.
- en=1 load, when F_AdEL=0: D_pc=F_pc, D_instr=F_instr, D_ExcCode=0, D_BD=F_BD, D_valid=1.
- en=1 load, when F_AdEL=1: D_pc=F_pc, D_instr=32'h0 (forced nop, so the fetched word is never decoded), D_ExcCode=EXC_ADEL, D_BD=F_BD, D_valid=1. D_pc keeps the faulting address so CP0 can report EPC/BadVAddr.
- ExcCode field: a fetch fault is the only exception originating here. Decode-stage exceptions (RI, syscall) are merged downstream and never written into this register.
- Flushed slots carry HANDLER_PC so that the macroscopic PC seen by CP0 stays monotonic into the handler. D_valid=0 flags them as not architecturally executed.
- No internal state beyond the register bank; no handshake with fetch other than en.

## Timing
- Latency: exactly 1 cycle from F-side inputs to D-side outputs when en=1.
- Stall: en=0 for N cycles holds outputs N cycles. The first en=1 cycle after the stall captures the inputs present in that cycle.
- Req during a stall still flushes on that edge. Req is sampled every cycle independent of en.
- reset and Req asserted together: reset values apply (D_pc=RESET_PC).
- Reset mid-operation: one edge with reset=1 fully clears the bank. There is no multi-cycle recovery.
- F_AdEL and F_instr only matter on a load edge; X on F_instr while F_AdEL=1 must not propagate (D_instr=0).
- Back-to-back loads: every enabled edge overwrites all fields; there are no partial updates.

## Test plan
- Reset: hold reset=1 one edge with arbitrary inputs -> D_pc=0x0000_3000, D_instr=0, D_ExcCode=0, D_BD=0, D_valid=0.
- Normal load: en=1, F_pc=0x0000_3004, F_instr=0x2408_0005, F_AdEL=0, F_BD=1 -> next cycle D_pc=0x3004, D_instr=0x2408_0005, D_ExcCode=0, D_BD=1, D_valid=1.
- Address error: en=1, F_pc=0x0000_3002, F_instr=0xFFFF_FFFF, F_AdEL=1 -> D_pc=0x3002, D_instr=0, D_ExcCode=4, D_valid=1.
- Stall hold: load 0x3008/0x0000_0000, then en=0 for 3 cycles with changing inputs -> outputs unchanged all 3 cycles; en=1 with F_pc=0x300C -> D_pc=0x300C next cycle.
- Req during stall: en=0, Req=1 one cycle -> D_pc=0x0000_4180, D_instr=0, D_ExcCode=0, D_BD=0, D_valid=0.
- Reset+Req same edge: reset=1, Req=1, en=1, F_pc=0x3010 -> D_pc=0x0000_3000, D_valid=0.
